bcd_multidigit_sub_seq: RTL and testbench

//  Digit-serial sequencer for the single-digit BCD subtractor. Latches two

---
 rtl/bcd_multidigit_sub_seq_if.sv | 25 ++
 rtl/bcd_multidigit_sub_seq.sv | 151 +++++++++++++++
 tb/tb_bcd_multidigit_sub_seq.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bcd_multidigit_sub_seq_if.sv
// Request/response bundle between the operand source and the BCD subtract sequencer.
interface bcd_multidigit_sub_seq_if #(
    parameter int unsigned NDIG = 4
) ();
    localparam int unsigned W = 4 * NDIG;

    logic         start;
    logic [W-1:0] a_bcd;
    logic [W-1:0] b_bcd;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         neg;
    logic         err;

    modport master (
        output start, a_bcd, b_bcd,
        input  busy, done, result, neg, err
    );

    modport slave (
        input  start, a_bcd, b_bcd,
        output busy, done, result, neg, err
    );
endinterface

// File: rtl/bcd_multidigit_sub_seq.sv
// Digit-serial BCD subtract sequencer: drives a combinational digit stage LSD first
// and returns sign-magnitude |A-B|, using a second 0-raw pass for negative results.
module bcd_multidigit_sub_seq #(
    parameter int unsigned NDIG = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bcd_multidigit_sub_seq_if.slave  bus,
    output logic [3:0]               sub_a,
    output logic [3:0]               sub_b,
    input  logic [3:0]               sub_s,
    input  logic                     sub_borrow
);
    localparam int unsigned W  = 4 * NDIG;
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SUB_B = 2'd1;
    localparam logic [1:0] S_SUB_C = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state, state_d;
    logic [W-1:0]  op_a, op_a_d, op_b, op_b_d, raw, raw_d, result_q, result_d;
    logic [IW-1:0] idx, idx_d;
    logic [3:0]    tmp, tmp_d;
    logic          borrow, borrow_d, b1, b1_d, pass, pass_d;
    logic          neg_q, neg_d, err_q, err_d, busy_q, busy_d, done_q, done_d;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next-state, datapath updates and digit-stage operand select
    always_comb begin
        state_d  = state;
        op_a_d   = op_a;
        op_b_d   = op_b;
        raw_d    = raw;
        idx_d    = idx;
        tmp_d    = tmp;
        borrow_d = borrow;
        b1_d     = b1;
        pass_d   = pass;
        neg_d    = neg_q;
        err_d    = err_q;
        sub_a    = 4'd0;
        sub_b    = 4'd0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    op_a_d   = bus.a_bcd;
                    op_b_d   = bus.b_bcd;
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    pass_d   = 1'b0;
                    neg_d    = 1'b0;
                    if (has_bad_digit(bus.a_bcd) || has_bad_digit(bus.b_bcd)) begin
                        err_d   = 1'b1;
                        raw_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_SUB_B;
                    end
                end
            end
            S_SUB_B: begin
                sub_a   = op_a[idx*4 +: 4];
                sub_b   = op_b[idx*4 +: 4];
                tmp_d   = sub_s;
                b1_d    = sub_borrow;
                state_d = S_SUB_C;
            end
            S_SUB_C: begin
                sub_a              = tmp;
                sub_b              = {3'b000, borrow};
                raw_d[idx*4 +: 4]  = sub_s;
                borrow_d           = b1 | sub_borrow;
                if (idx < IW'(NDIG - 1)) begin
                    idx_d   = idx + IW'(1);
                    state_d = S_SUB_B;
                end else if (!pass && borrow_d) begin
                    // Negative raw: subtract it from zero to get the magnitude
                    neg_d    = 1'b1;
                    op_a_d   = '0;
                    op_b_d   = raw_d;
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    pass_d   = 1'b1;
                    state_d  = S_SUB_B;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        result_d = done_d ? raw_d : result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            raw      <= '0;
            result_q <= '0;
            idx      <= '0;
            tmp      <= 4'd0;
            borrow   <= 1'b0;
            b1       <= 1'b0;
            pass     <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            op_a     <= op_a_d;
            op_b     <= op_b_d;
            raw      <= raw_d;
            result_q <= result_d;
            idx      <= idx_d;
            tmp      <= tmp_d;
            borrow   <= borrow_d;
            b1       <= b1_d;
            pass     <= pass_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.neg    = neg_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_bcd_multidigit_sub_seq.sv
// Directed bench for the BCD subtract sequencer with a behavioural digit stage.
module tb_bcd_multidigit_sub_seq;
    logic       clk;
    logic       rst_n;
    logic [3:0] sub_a, sub_b, sub_s;
    logic       sub_borrow;
    int         n_assert;
    int         n_fail;

    bcd_multidigit_sub_seq_if #(.NDIG(4)) bus_if ();

    bcd_multidigit_sub_seq #(.NDIG(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_s      (sub_s),
        .sub_borrow (sub_borrow)
    );

    // Combinational digit stage: S = (A-B) mod 10, borrow iff A<B
    always_comb begin
        sub_borrow = (sub_a < sub_b);
        sub_s      = sub_borrow ? 4'(sub_a + 4'd10 - sub_b) : 4'(sub_a - sub_b);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input logic exp_neg,
                          input logic exp_err, input int lat, input int poke);
        int   cyc;
        logic seen;
        @(negedge clk);
        bus_if.a_bcd = a;
        bus_if.b_bcd = b;
        bus_if.start = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == poke) begin
                bus_if.start = 1'b1;
                bus_if.a_bcd = 16'h9999;
                bus_if.b_bcd = 16'h0000;
            end else begin
                bus_if.start = 1'b0;
            end
            if (cyc == 1) begin
                check({tag, "/busy_c1"}, 32'(bus_if.busy), 32'd1);
                check({tag, "/neg_c1"}, 32'(bus_if.neg), 32'd0);
                check({tag, "/err_c1"}, 32'(bus_if.err), 32'(exp_err));
            end
            if (bus_if.done) seen = 1'b1;
        end
        check({tag, "/latency"}, 32'(cyc), 32'(lat));
        check({tag, "/result"}, 32'(bus_if.result), 32'(exp_res));
        check({tag, "/neg"}, 32'(bus_if.neg), 32'(exp_neg));
        check({tag, "/err"}, 32'(bus_if.err), 32'(exp_err));
        check({tag, "/busy_done"}, 32'(bus_if.busy), 32'd1);
        @(negedge clk);
        bus_if.start = 1'b0;
        check({tag, "/done_pulse"}, 32'(bus_if.done), 32'd0);
        check({tag, "/idle_busy"}, 32'(bus_if.busy), 32'd0);
        check({tag, "/idle_sub"}, 32'({sub_a, sub_b}), 32'd0);
        check({tag, "/hold_result"}, 32'(bus_if.result), 32'(exp_res));
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.a_bcd = 16'h0000;
        bus_if.b_bcd = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset/outs", 32'({bus_if.busy, bus_if.done, bus_if.neg, bus_if.err}), 32'd0);
        check("reset/result", 32'(bus_if.result), 32'd0);
        check("reset/sub", 32'({sub_a, sub_b}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op("T1", 16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0, 9, 0);
        run_op("T6b", 16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0, 9, 3);
        run_op("T2", 16'h0034, 16'h1234, 16'h1200, 1'b1, 1'b0, 17, 0);
        run_op("T3", 16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 9, 0);
        run_op("T4a", 16'h5678, 16'h5678, 16'h0000, 1'b0, 1'b0, 9, 0);
        run_op("T4b", 16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 17, 0);
        run_op("T5", 16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1, 0);
        run_op("T5clr", 16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0, 9, 0);

        // Reset in the middle of a negative-result operation
        @(negedge clk);
        bus_if.a_bcd = 16'h0034;
        bus_if.b_bcd = 16'h1234;
        bus_if.start = 1'b1;
        repeat (5) begin
            @(negedge clk);
            bus_if.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("T6a/outs", 32'({bus_if.busy, bus_if.done, bus_if.neg, bus_if.err}), 32'd0);
        check("T6a/result", 32'(bus_if.result), 32'd0);
        check("T6a/sub", 32'({sub_a, sub_b}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("T6a/no_done", 32'(bus_if.done), 32'd0);
        end

        run_op("T7", 16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 9, 0);
        run_op("T8", 16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 17, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
